// File: rtl/alu.sv
// 32-bit integer ALU: combinational result/zero/last_bit plus a one-cycle
// registered copy of all three, cleared asynchronously by rst_n.
module alu (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] src1,
    input  logic [31:0] src2,
    input  logic [3:0]  alu_control,
    output logic [31:0] alu_result,
    output logic        zero,
    output logic        last_bit,
    output logic [31:0] alu_result_q,
    output logic        zero_q,
    output logic        last_bit_q
);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SLL  = 4'b0101;
    localparam logic [3:0] OP_SRL  = 4'b0110;
    localparam logic [3:0] OP_SRA  = 4'b0111;
    localparam logic [3:0] OP_SLT  = 4'b1000;
    localparam logic [3:0] OP_SLTU = 4'b1001;

    logic [4:0]  shamt_s;
    logic [31:0] result_s;
    logic        zero_s;
    logic        src2_unused_s;

    // Only the low five bits of src2 form the shift amount; the rest are
    // deliberately ignored for shifts.
    assign shamt_s       = src2[4:0];
    assign src2_unused_s = ^src2[31:5];

    // Operation decode; reserved encodings yield zero.
    always_comb begin
        result_s = 32'h0000_0000;
        case (alu_control)
            OP_ADD:  result_s = src1 + src2;
            OP_SUB:  result_s = src1 - src2;
            OP_AND:  result_s = src1 & src2;
            OP_OR:   result_s = src1 | src2;
            OP_XOR:  result_s = src1 ^ src2;
            OP_SLL:  result_s = src1 << shamt_s;
            OP_SRL:  result_s = src1 >> shamt_s;
            OP_SRA:  result_s = $unsigned($signed(src1) >>> shamt_s);
            OP_SLT:  result_s = {31'h0000_0000, ($signed(src1) < $signed(src2))};
            OP_SLTU: result_s = {31'h0000_0000, (src1 < src2)};
            default: result_s = 32'h0000_0000;
        endcase
    end

    // Flags derived directly from the result so they hold for every opcode.
    always_comb begin
        zero_s = 1'b0;
        if (result_s == 32'h0000_0000) begin
            zero_s = 1'b1;
        end else begin
            zero_s = 1'b0;
        end
    end

    assign alu_result = result_s;
    assign zero       = zero_s;
    assign last_bit   = result_s[0];

    // One-cycle capture of the combinational outputs; reset clears all three,
    // including zero_q, even though the live zero flag may be high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_result_q <= 32'h0000_0000;
            zero_q       <= 1'b0;
            last_bit_q   <= 1'b0;
        end else begin
            alu_result_q <= result_s;
            zero_q       <= zero_s;
            last_bit_q   <= result_s[0];
        end
    end

endmodule

// File: tb/tb_alu.sv
// Directed self-checking bench for alu: combinational opcodes and boundaries,
// random ADD / reserved-opcode sweeps, and the registered/reset path.
module tb_alu;

    logic        clk;
    logic        rst_n;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [3:0]  alu_control;
    logic [31:0] alu_result;
    logic        zero;
    logic        last_bit;
    logic [31:0] alu_result_q;
    logic        zero_q;
    logic        last_bit_q;

    int tests_run;
    int tests_failed;

    alu dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .src1         (src1),
        .src2         (src2),
        .alu_control  (alu_control),
        .alu_result   (alu_result),
        .zero         (zero),
        .last_bit     (last_bit),
        .alu_result_q (alu_result_q),
        .zero_q       (zero_q),
        .last_bit_q   (last_bit_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[$];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %08h, expected %08h", tag, obs, exp);
        end
    endtask

    task automatic apply(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        alu_control = op;
        src1        = a;
        src2        = b;
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;

        tests_run    = 0;
        tests_failed = 0;
        rst_n        = 1'b0;
        alu_control  = 4'b0000;
        src1         = 32'h0000_0000;
        src2         = 32'h0000_0000;

        vecs.push_back('{"add_cancel",   4'b0000, 32'd12345,      32'hFFFF_CFC7, 32'h0000_0000});
        vecs.push_back('{"add_ovf",      4'b0000, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000});
        vecs.push_back('{"sub_neg",      4'b0001, 32'd3,          32'd10,        32'hFFFF_FFF9});
        vecs.push_back('{"sub_pos",      4'b0001, 32'd10,         32'd3,         32'h0000_0007});
        vecs.push_back('{"and",          4'b0010, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000});
        vecs.push_back('{"or",           4'b0011, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0});
        vecs.push_back('{"xor",          4'b0100, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0});
        vecs.push_back('{"sll_msb",      4'b0101, 32'h8000_0000, 32'h0000_0024, 32'h0000_0000});
        vecs.push_back('{"srl_msb",      4'b0110, 32'h8000_0000, 32'h0000_0024, 32'h0800_0000});
        vecs.push_back('{"sra_msb",      4'b0111, 32'h8000_0000, 32'h0000_0024, 32'hF800_0000});
        vecs.push_back('{"sll_by0",      4'b0101, 32'h1234_5679, 32'h0000_0020, 32'h1234_5679});
        vecs.push_back('{"sll_5",        4'b0101, 32'h0000_0003, 32'hFFFF_FFE5, 32'h0000_0060});
        vecs.push_back('{"srl_4",        4'b0110, 32'hF000_0000, 32'h0000_0004, 32'h0F00_0000});
        vecs.push_back('{"sra_31_neg",   4'b0111, 32'h8000_0000, 32'h0000_001F, 32'hFFFF_FFFF});
        vecs.push_back('{"sra_31_pos",   4'b0111, 32'h7FFF_FFFF, 32'h0000_001F, 32'h0000_0000});
        vecs.push_back('{"sra_pos_4",    4'b0111, 32'h7000_0000, 32'h0000_0004, 32'h0700_0000});
        vecs.push_back('{"slt_m1_1",     4'b1000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001});
        vecs.push_back('{"sltu_m1_1",    4'b1001, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000});
        vecs.push_back('{"slt_1_m1",     4'b1000, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000});
        vecs.push_back('{"sltu_1_m1",    4'b1001, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0001});
        vecs.push_back('{"slt_eq",       4'b1000, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000});
        vecs.push_back('{"rsv_1010",     4'b1010, 32'hA5A5_A5A5, 32'h5A5A_5A5B, 32'h0000_0000});

        // Reset asserted at time 0: registered outputs already cleared.
        #1;
        check_eq("rst_result_q", alu_result_q, 32'h0000_0000);
        check_eq("rst_zero_q",   {31'h0, zero_q},     32'h0000_0000);
        check_eq("rst_last_q",   {31'h0, last_bit_q}, 32'h0000_0000);

        // Combinational path works during reset, with no clock dependence.
        foreach (vecs[i]) begin
            apply(vecs[i].op, vecs[i].a, vecs[i].b);
            check_eq(vecs[i].tag, alu_result, vecs[i].exp);
            check_eq({vecs[i].tag, "_zero"}, {31'h0, zero},
                     (vecs[i].exp == 32'h0) ? 32'h1 : 32'h0);
            check_eq({vecs[i].tag, "_lsb"}, {31'h0, last_bit}, {31'h0, vecs[i].exp[0]});
        end

        for (int i = 0; i < 1000; i++) begin
            ra = $urandom;
            rb = $urandom;
            apply(4'b0000, ra, rb);
            check_eq("add_rand", alu_result, ra + rb);
        end

        for (int i = 0; i < 20; i++) begin
            apply(4'b1111, $urandom, $urandom);
            check_eq("rsv_1111", alu_result, 32'h0000_0000);
            check_eq("rsv_1111_zero", {31'h0, zero}, 32'h0000_0001);
            check_eq("rsv_1111_lsb", {31'h0, last_bit}, 32'h0000_0000);
        end

        // Clock runs while in reset: registered outputs must stay cleared.
        apply(4'b0001, 32'd10, 32'd3);
        repeat (3) @(posedge clk);
        #1;
        check_eq("hold_rst_q",    alu_result_q, 32'h0000_0000);
        check_eq("hold_rst_last", {31'h0, last_bit_q}, 32'h0000_0000);
        check_eq("track_in_rst",  alu_result, 32'h0000_0007);

        // Release away from the edge; first posedge loads SUB 10-3.
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_eq("pre_edge_q", alu_result_q, 32'h0000_0000);
        @(posedge clk);
        #1;
        check_eq("sub_q",      alu_result_q, 32'h0000_0007);
        check_eq("sub_zero_q", {31'h0, zero_q},     32'h0000_0000);
        check_eq("sub_last_q", {31'h0, last_bit_q}, 32'h0000_0001);

        @(negedge clk);
        apply(4'b0000, 32'd12345, 32'hFFFF_CFC7);
        check_eq("q_latency", alu_result_q, 32'h0000_0007);
        @(posedge clk);
        #1;
        check_eq("add0_q",      alu_result_q, 32'h0000_0000);
        check_eq("add0_zero_q", {31'h0, zero_q}, 32'h0000_0001);

        @(negedge clk);
        apply(4'b0100, 32'hFFFF_0000, 32'h0000_FFFF);
        @(posedge clk);
        #1;
        check_eq("xor_q", alu_result_q, 32'hFFFF_FFFF);

        // Mid-cycle reset clears immediately, before any clock edge.
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_q",    alu_result_q, 32'h0000_0000);
        check_eq("mid_rst_last", {31'h0, last_bit_q}, 32'h0000_0000);
        check_eq("mid_rst_comb", alu_result, 32'hFFFF_FFFF);

        @(negedge clk);
        rst_n = 1'b1;
        apply(4'b1000, 32'hFFFF_FFFF, 32'h0000_0001);
        @(posedge clk);
        #1;
        check_eq("slt_q",      alu_result_q, 32'h0000_0001);
        check_eq("slt_last_q", {31'h0, last_bit_q}, 32'h0000_0001);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/alu.md
ALU -- requirements
Module: alu

Interface
REQ-001 The block SHALL have no parameters; all datapaths SHALL be fixed at 32 bits.
REQ-002 clk  input  1  single clock; all registered state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 src1  input  32  operand A.
REQ-005 src2  input  32  operand B; shift amount is src2[4:0].
REQ-006 alu_control  input  4  operation select.
REQ-007 alu_result  output  32  combinational result.
REQ-008 zero  output  1  combinational; 1 iff alu_result == 0.
REQ-009 last_bit  output  1  combinational; equals alu_result[0].
REQ-010 alu_result_q  output  32  alu_result registered on clk.
REQ-011 zero_q  output  1  zero registered on clk.
REQ-012 last_bit_q  output  1  last_bit registered on clk.

Function
REQ-013 alu_result SHALL be purely combinational from src1, src2 and alu_control, with no dependence on clk or rst_n.
REQ-014 The alu_control encoding SHALL be:
- 0000 ADD: src1+src2, modulo 2^32, carry discarded
- 0001 SUB: src1-src2, modulo 2^32
- 0010 AND
- 0011 OR
- 0100 XOR
- 0101 SLL: src1 << src2[4:0]
- 0110 SRL: logical right shift by src2[4:0]
- 0111 SRA: arithmetic right shift by src2[4:0], sign bit replicated
- 1000 SLT: 1 if $signed(src1) < $signed(src2), else 0
- 1001 SLTU: 1 if src1 < src2 unsigned, else 0
REQ-015 Encodings 1010-1111 SHALL drive alu_result = 32'h0, so zero=1 and last_bit=0.
REQ-016 For SLT and SLTU, alu_result[31:1] SHALL be 0, so last_bit carries the comparison outcome.
REQ-017 Shift boundaries:
- src2[31:5] SHALL be ignored.
- A shift by 0 SHALL return src1 unchanged.
- SRA by 31 SHALL return 32'hFFFFFFFF if src1[31]=1, else 0.
REQ-018 Overflow SHALL be ignored for ADD and SUB; no overflow or carry flag exists. Example: 32'h7FFFFFFF+1 = 32'h80000000.
REQ-019 zero SHALL be 1 exactly when all 32 alu_result bits are 0, for every operation including the default.
REQ-020 On each rising clk edge with rst_n=1, alu_result_q, zero_q and last_bit_q SHALL capture the current alu_result, zero and last_bit (latency 1 cycle, no enable).
REQ-021 The combinational outputs SHALL settle within the same evaluation step as an input change; no cycle latency is allowed on alu_result, zero or last_bit.

Reset
REQ-022 Asserting rst_n=0 SHALL immediately, without waiting for a clk edge, force:
- alu_result_q = 0
- zero_q = 0
- last_bit_q = 0
REQ-023 While rst_n=0, the registered outputs SHALL hold those values regardless of clk.
REQ-024 Reset SHALL NOT affect alu_result, zero or last_bit; they continue to track the inputs during reset.
REQ-025 After rst_n deasserts, the first rising clk edge SHALL load the current combinational values.
REQ-026 Reset asserted mid-stream SHALL discard the captured value; no other state exists.

Verification
REQ-027 ADD, 1000 random src1/src2 pairs, alu_control=0000 -> alu_result == (src1+src2) mod 2^32 after 1 ns settle, with no clock required.
REQ-028 alu_control=1111, random operands -> alu_result=0, zero=1, last_bit=0.
REQ-029 ADD, src1=12345, src2=-12345 (32'hFFFFCFC7) -> alu_result=0, zero=1.
REQ-030 SLT/SLTU, src1=32'hFFFFFFFF, src2=1:
- SLT -> alu_result=1, last_bit=1
- SLTU -> alu_result=0, zero=1
REQ-031 Shifts, src1=32'h80000000, src2=32'h00000024 (shift 4):
- SRA -> 32'hF8000000
- SRL -> 32'h08000000
- SLL -> 0, zero=1
REQ-032 Registered path:
- rst_n=0 -> all _q outputs 0 immediately.
- Release reset, apply SUB 10-3 -> alu_result_q=7 after the next posedge.
- Pull rst_n low mid-cycle -> alu_result_q=0 at once, before any clock edge.
